memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly downstream of execute.
- Consumes the execute result (effective address or ALU value), the rs2 store data and the load/store/writeback control.
- Performs byte/half/word loads and stores over a req/ack data-memory handshake and stalls upstream while an access is outstanding.
- Delivers the final writeback value to the writeback stage and exposes a forwarding path.

Parameters:
- WAIT_LIMIT, 16, max cycles waiting for dm_ack before the access is abandoned and bus_error pulses.

Ports:
- clk  input  1  pipeline clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- pc_input  input  32  instruction pc from execute
- result_input  input  32  ALU/shift result; effective address for loads/stores
- rs2_value_input  input  32  store data
- read_status_input  input  2  `DM_NONE/`DM_BYTE/`DM_HALF/`DM_WORD load width
- write_status_input  input  2  same encoding, store width
- load_signed_input  input  1  1 = sign-extend load
- destination_register_number_input  input  5  rd
- write_back_type_input  input  2  `WB_*; `WB_HICCUP = bubble
- dm_req  output  1  memory request
- dm_we  output  1  1 = store
- dm_addr  output  32  word-aligned address ({result[31:2],2'b00})
- dm_wdata  output  32  store data replicated into lanes
- dm_wstrb  output  4  byte enables
- dm_ack  input  1  memory completion, sampled at posedge
- dm_rdata  input  32  load word, valid with dm_ack
- stall  output  1  upstream must hold its outputs
- bus_error  output  1  one-cycle pulse on timeout
- pc_output  output  32  to writeback
- result_output  output  32  writeback value
- destination_register_number_output  output  5  to writeback
- write_back_type_output  output  2  to writeback
- value_forward  output  32  combinational, current non-load result
- register_forward  output  5  combinational rd
- forward_enable  output  1  combinational

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; dm_req=0, dm_we=0, dm_wstrb=0, stall=0, bus_error=0.
  - write_back_type_output=`WB_HICCUP; all other outputs 0.
- States:
  - IDLE accepts an input every posedge. Non-memory op (both status `DM_NONE, or type `WB_HICCUP) → registered to outputs with 1-cycle latency.
  - Memory op → latch inputs and go to ACCESS. In ACCESS, dm_req, dm_we, dm_addr, dm_wdata and dm_wstrb are registered and held stable until ack. stall=1 combinationally while in ACCESS.
  - During ACCESS, write_back_type_output=`WB_HICCUP.
- Ack: posedge with dm_ack=1 in ACCESS:
  - dm_req drops and state returns to IDLE.
  - For loads, result_output = extended lane data; for stores, write_back_type_output=`WB_HICCUP. Both take effect on that same edge.
  - The following cycle, IDLE accepts the next input (the held upstream instruction). Load-to-writeback latency is 1 + ack wait cycles.
- Lanes:
  - byte: lane = addr[1:0]; wstrb=0001<<addr[1:0]; wdata={4{rs2[7:0]}}.
  - half: lane = addr[1]; wstrb=0011<<(2*addr[1]); wdata={2{rs2[15:0]}}.
  - word: wstrb=1111.
  - Load extension: sign if load_signed_input, else zero.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): low bits ignored; the access is done at the aligned lane (feature off).
- Timeout: WAIT_LIMIT cycles in ACCESS without ack → pulse bus_error, drop dm_req, return to IDLE, output `WB_HICCUP.
- Forwarding: forward_enable = (write_back_type_input==`WB_NORMAL) && rd!=0 && read_status_input==`DM_NONE && state==IDLE. Load results are never forwarded from this stage.
- Reset mid-access: dm_req drops immediately (async); the access is discarded.
- dm_ack in IDLE is ignored.

Optional Feature:
- MISALIGN_TRAP_EN
  - Defined: misaligned access issues no dm_req, outputs `WB_HICCUP, and pulses bus_error for one cycle.
  - Undefined: misaligned accesses are silently aligned (as above).

Test Plan:
- ALU passthrough: result=0x1234, rd=5, `WB_NORMAL, no mem → next cycle result_output=0x1234, rd=5; forward_enable=1 same cycle.
- Signed byte load: addr=0x103, dm_rdata=0x80FFFF00, ack after 2 cycles → dm_addr=0x100; stall high 3 cycles; result_output=0xFFFFFF80.
- Unsigned half load: addr=0x102, rdata=0xBEEF1234 → result_output=0x0000BEEF.
- Half store: addr=0x202, rs2=0xCAFEABCD → dm_we=1, dm_wstrb=1100, dm_wdata=0xABCDABCD; after ack, write_back_type_output=`WB_HICCUP.
- Timeout: load, dm_ack held 0 → bus_error pulses after 16 cycles; stall releases.
- Async reset asserted mid-ACCESS → dm_req=0 and write_back_type_output=`WB_HICCUP with no clock edge.

Source files
------------

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module   : memory_access
// Purpose  : Memory stage: byte/half/word loads and stores over a req/ack
//            data-memory bus, stalling upstream while an access is pending.
// Options  : MISALIGN_TRAP_EN - misaligned accesses raise bus_error instead
//            of being silently aligned.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef DM_NONE
`define DM_NONE 2'd0
`define DM_BYTE 2'd1
`define DM_HALF 2'd2
`define DM_WORD 2'd3
`endif

`ifndef WB_HICCUP
`define WB_HICCUP 2'd0
`define WB_NORMAL 2'd1
`define WB_LOAD   2'd2
`define WB_OTHER  2'd3
`endif

module memory_access #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_input,
   input  logic [31:0] result_input,
   input  logic [31:0] rs2_value_input,
   input  logic [1:0]  read_status_input,
   input  logic [1:0]  write_status_input,
   input  logic        load_signed_input,
   input  logic [4:0]  destination_register_number_input,
   input  logic [1:0]  write_back_type_input,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_wstrb,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall,
   output logic        bus_error,
   output logic [31:0] pc_output,
   output logic [31:0] result_output,
   output logic [4:0]  destination_register_number_output,
   output logic [1:0]  write_back_type_output,
   output logic [31:0] value_forward,
   output logic [4:0]  register_forward,
   output logic        forward_enable
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   localparam int c_CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_LIMIT - 1);
`ifdef MISALIGN_TRAP_EN
   localparam logic c_TRAP_EN = 1'b1;
`else
   localparam logic c_TRAP_EN = 1'b0;
`endif

   state_t              r_state;
   state_t              w_state_next;
   logic [c_CNT_W-1:0]  r_wait_cnt;
   logic                r_is_load;
   logic                r_signed;
   logic [1:0]          r_width;
   logic [1:0]          r_lane_off;
   logic [1:0]          r_wb_type;

   logic                w_is_load;
   logic                w_is_store;
   logic                w_mem_op;
   logic                w_trap;
   logic                w_timeout;
   logic                w_misaligned;
   logic [1:0]          w_width;
   logic [1:0]          w_addr_lo;
   logic [1:0]          w_lane_off;
   logic [3:0]          w_wstrb;
   logic [31:0]         w_wdata;
   logic [31:0]         w_shifted;
   logic [31:0]         w_load_val;

   assign w_is_load  = (read_status_input != `DM_NONE);
   assign w_is_store = (write_status_input != `DM_NONE);
   assign w_mem_op   = (w_is_load || w_is_store) && (write_back_type_input != `WB_HICCUP);
   assign w_width    = w_is_load ? read_status_input : write_status_input;
   assign w_addr_lo  = result_input[1:0];
   assign w_trap     = c_TRAP_EN && w_mem_op && w_misaligned;

   // Lane placement: misaligned low address bits fall away to the natural lane.
   always_comb begin
      w_misaligned = 1'b0;
      w_lane_off   = 2'b00;
      w_wstrb      = 4'b0000;
      w_wdata      = rs2_value_input;
      case (w_width)
         `DM_BYTE: begin
            w_lane_off = w_addr_lo;
            w_wstrb    = 4'b0001 << w_addr_lo;
            w_wdata    = {4{rs2_value_input[7:0]}};
         end
         `DM_HALF: begin
            w_misaligned = w_addr_lo[0];
            w_lane_off   = {w_addr_lo[1], 1'b0};
            w_wstrb      = w_addr_lo[1] ? 4'b1100 : 4'b0011;
            w_wdata      = {2{rs2_value_input[15:0]}};
         end
         `DM_WORD: begin
            w_misaligned = (w_addr_lo != 2'b00);
            w_wstrb      = 4'b1111;
         end
         default: ;
      endcase
   end

   assign w_shifted = dm_rdata >> {r_lane_off, 3'b000};

   always_comb begin
      w_load_val = w_shifted;
      case (r_width)
         `DM_BYTE: w_load_val = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
         `DM_HALF: w_load_val = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
         default:  w_load_val = w_shifted;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op && !w_trap) w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (dm_ack) begin
               w_state_next = S_IDLE;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dm_req                             <= 1'b0;
         dm_we                              <= 1'b0;
         dm_addr                            <= 32'd0;
         dm_wdata                           <= 32'd0;
         dm_wstrb                           <= 4'b0000;
         bus_error                          <= 1'b0;
         pc_output                          <= 32'd0;
         result_output                      <= 32'd0;
         destination_register_number_output <= 5'd0;
         write_back_type_output             <= `WB_HICCUP;
         r_wait_cnt                         <= '0;
         r_is_load                          <= 1'b0;
         r_signed                           <= 1'b0;
         r_width                            <= `DM_NONE;
         r_lane_off                         <= 2'b00;
         r_wb_type                          <= `WB_HICCUP;
      end else begin
         bus_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               pc_output                          <= pc_input;
               result_output                      <= result_input;
               destination_register_number_output <= destination_register_number_input;
               if (!w_mem_op) begin
                  write_back_type_output <= write_back_type_input;
               end else begin
                  // Writeback stays a bubble until the access resolves.
                  write_back_type_output <= `WB_HICCUP;
                  if (w_trap) begin
                     bus_error <= 1'b1;
                  end else begin
                     dm_req     <= 1'b1;
                     dm_we      <= !w_is_load;
                     dm_addr    <= {result_input[31:2], 2'b00};
                     dm_wdata   <= w_wdata;
                     dm_wstrb   <= w_is_load ? 4'b0000 : w_wstrb;
                     r_wait_cnt <= '0;
                     r_is_load  <= w_is_load;
                     r_signed   <= load_signed_input;
                     r_width    <= w_width;
                     r_lane_off <= w_lane_off;
                     r_wb_type  <= write_back_type_input;
                  end
               end
            end
            S_ACCESS: begin
               if (dm_ack || w_timeout) begin
                  dm_req   <= 1'b0;
                  dm_we    <= 1'b0;
                  dm_wstrb <= 4'b0000;
               end
               if (dm_ack) begin
                  if (r_is_load) begin
                     result_output          <= w_load_val;
                     write_back_type_output <= r_wb_type;
                  end else begin
                     write_back_type_output <= `WB_HICCUP;
                  end
               end else if (w_timeout) begin
                  bus_error              <= 1'b1;
                  write_back_type_output <= `WB_HICCUP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign stall            = (r_state == S_ACCESS);
   assign value_forward    = result_input;
   assign register_forward = destination_register_number_input;
   assign forward_enable   = (write_back_type_input == `WB_NORMAL)
                          && (destination_register_number_input != 5'd0)
                          && (read_status_input == `DM_NONE)
                          && (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access
// Purpose  : Directed self-checking bench for memory_access.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef DM_NONE
`define DM_NONE 2'd0
`define DM_BYTE 2'd1
`define DM_HALF 2'd2
`define DM_WORD 2'd3
`endif

`ifndef WB_HICCUP
`define WB_HICCUP 2'd0
`define WB_NORMAL 2'd1
`define WB_LOAD   2'd2
`define WB_OTHER  2'd3
`endif

module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_input = '0;
   logic [31:0] result_input = '0;
   logic [31:0] rs2_value_input = '0;
   logic [1:0]  read_status_input = `DM_NONE;
   logic [1:0]  write_status_input = `DM_NONE;
   logic        load_signed_input = 1'b0;
   logic [4:0]  destination_register_number_input = '0;
   logic [1:0]  write_back_type_input = `WB_HICCUP;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic        stall;
   logic        bus_error;
   logic [31:0] pc_output;
   logic [31:0] result_output;
   logic [4:0]  destination_register_number_output;
   logic [1:0]  write_back_type_output;
   logic [31:0] value_forward;
   logic [4:0]  register_forward;
   logic        forward_enable;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_access #(.WAIT_LIMIT(16)) dut (
      .clk                                (clk),
      .reset                              (reset),
      .pc_input                           (pc_input),
      .result_input                       (result_input),
      .rs2_value_input                    (rs2_value_input),
      .read_status_input                  (read_status_input),
      .write_status_input                 (write_status_input),
      .load_signed_input                  (load_signed_input),
      .destination_register_number_input  (destination_register_number_input),
      .write_back_type_input              (write_back_type_input),
      .dm_req                             (dm_req),
      .dm_we                              (dm_we),
      .dm_addr                            (dm_addr),
      .dm_wdata                           (dm_wdata),
      .dm_wstrb                           (dm_wstrb),
      .dm_ack                             (dm_ack),
      .dm_rdata                           (dm_rdata),
      .stall                              (stall),
      .bus_error                          (bus_error),
      .pc_output                          (pc_output),
      .result_output                      (result_output),
      .destination_register_number_output (destination_register_number_output),
      .write_back_type_output             (write_back_type_output),
      .value_forward                      (value_forward),
      .register_forward                   (register_forward),
      .forward_enable                     (forward_enable)
   );

   task automatic drive(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rs2,
                        input logic [1:0] rd_st, input logic [1:0] wr_st, input logic sgn,
                        input logic [4:0] rd, input logic [1:0] wbt);
      pc_input = pc; result_input = res; rs2_value_input = rs2;
      read_status_input = rd_st; write_status_input = wr_st; load_signed_input = sgn;
      destination_register_number_input = rd; write_back_type_input = wbt;
   endtask

   task automatic drive_nop();
      drive(32'd0, 32'd0, 32'd0, `DM_NONE, `DM_NONE, 1'b0, 5'd0, `WB_HICCUP);
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req: got %b want 0", dm_req); end
      n_checks++; if (dm_wstrb !== 4'b0000) begin n_fail++; $display("FAIL reset_dm_wstrb: got %b want 0000", dm_wstrb); end
      n_checks++; if (stall !== 1'b0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_stall_buserr: got %b%b want 00", stall, bus_error); end
      n_checks++; if (write_back_type_output !== `WB_HICCUP) begin n_fail++; $display("FAIL reset_wb_type: got %0d want %0d", write_back_type_output, `WB_HICCUP); end
      n_checks++; if (result_output !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_output); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_alu_passthrough();
      @(negedge clk);
      drive(32'h40, 32'h1234, 32'h0, `DM_NONE, `DM_NONE, 1'b0, 5'd5, `WB_NORMAL);
      #1;
      n_checks++; if (forward_enable !== 1'b1) begin n_fail++; $display("FAIL alu_fwd_en: got %b want 1", forward_enable); end
      n_checks++; if (value_forward !== 32'h1234 || register_forward !== 5'd5) begin n_fail++; $display("FAIL alu_fwd_val: got %h/%0d want 1234/5", value_forward, register_forward); end
      @(negedge clk);
      drive(32'h44, 32'h9999, 32'h0, `DM_NONE, `DM_NONE, 1'b0, 5'd0, `WB_NORMAL);
      #1;
      n_checks++; if (result_output !== 32'h1234 || destination_register_number_output !== 5'd5) begin n_fail++; $display("FAIL alu_result: got %h/%0d want 1234/5", result_output, destination_register_number_output); end
      n_checks++; if (write_back_type_output !== `WB_NORMAL || pc_output !== 32'h40) begin n_fail++; $display("FAIL alu_wb_pc: got %0d/%h want %0d/40", write_back_type_output, pc_output, `WB_NORMAL); end
      n_checks++; if (forward_enable !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_rd0: got %b want 0", forward_enable); end
      @(negedge clk);
      n_checks++; if (result_output !== 32'h9999) begin n_fail++; $display("FAIL alu_back_to_back: got %h want 9999", result_output); end
   endtask

   task automatic test_signed_byte_load();
      int stall_cnt = 0;
      @(negedge clk);
      drive(32'h80, 32'h103, 32'h0, `DM_BYTE, `DM_NONE, 1'b1, 5'd7, `WB_LOAD);
      #1;
      n_checks++; if (forward_enable !== 1'b0) begin n_fail++; $display("FAIL sbyte_no_fwd: got %b want 0", forward_enable); end
      @(negedge clk);
      // Upstream holds the next ALU instruction while stalled.
      drive(32'h84, 32'h55, 32'h0, `DM_NONE, `DM_NONE, 1'b0, 5'd3, `WB_NORMAL);
      #1;
      n_checks++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h100) begin n_fail++; $display("FAIL sbyte_req: got req=%b we=%b addr=%h want 1/0/100", dm_req, dm_we, dm_addr); end
      n_checks++; if (write_back_type_output !== `WB_HICCUP || forward_enable !== 1'b0) begin n_fail++; $display("FAIL sbyte_bubble: got wb=%0d fwd=%b want 0/0", write_back_type_output, forward_enable); end
      for (int i = 0; i < 3; i++) begin
         if (stall) stall_cnt++;
         if (i == 2) begin dm_ack = 1'b1; dm_rdata = 32'h80FFFF00; end
         @(negedge clk);
      end
      dm_ack = 1'b0; dm_rdata = 32'h0;
      n_checks++; if (stall_cnt != 3 || stall !== 1'b0) begin n_fail++; $display("FAIL sbyte_stall: got %0d cycles stall_now=%b want 3/0", stall_cnt, stall); end
      n_checks++; if (result_output !== 32'hFFFFFF80 || dm_req !== 1'b0) begin n_fail++; $display("FAIL sbyte_result: got %h req=%b want ffffff80/0", result_output, dm_req); end
      n_checks++; if (write_back_type_output !== `WB_LOAD || destination_register_number_output !== 5'd7) begin n_fail++; $display("FAIL sbyte_wb: got %0d/%0d want %0d/7", write_back_type_output, destination_register_number_output, `WB_LOAD); end
      @(negedge clk);
      drive_nop();
      n_checks++; if (result_output !== 32'h55 || destination_register_number_output !== 5'd3) begin n_fail++; $display("FAIL sbyte_held_next: got %h/%0d want 55/3", result_output, destination_register_number_output); end
   endtask

   task automatic test_unsigned_half_load();
      @(negedge clk);
      drive(32'h90, 32'h102, 32'h0, `DM_HALF, `DM_NONE, 1'b0, 5'd9, `WB_LOAD);
      @(negedge clk);
      drive_nop();
      dm_ack = 1'b1; dm_rdata = 32'hBEEF1234;
      @(negedge clk);
      dm_ack = 1'b0;
      n_checks++; if (result_output !== 32'h0000BEEF) begin n_fail++; $display("FAIL uhalf_result: got %h want 0000beef", result_output); end
   endtask

   task automatic test_misaligned_word_load();
      @(negedge clk);
      drive(32'h94, 32'h106, 32'h0, `DM_WORD, `DM_NONE, 1'b1, 5'd10, `WB_LOAD);
      @(negedge clk);
      drive_nop();
      n_checks++; if (dm_req !== 1'b1 || dm_addr !== 32'h104) begin n_fail++; $display("FAIL misword_addr: got req=%b addr=%h want 1/104", dm_req, dm_addr); end
      dm_ack = 1'b1; dm_rdata = 32'h11223344;
      @(negedge clk);
      dm_ack = 1'b0;
      n_checks++; if (result_output !== 32'h11223344) begin n_fail++; $display("FAIL misword_result: got %h want 11223344", result_output); end
   endtask

   task automatic test_stores();
      @(negedge clk);
      drive(32'hA0, 32'h202, 32'hCAFEABCD, `DM_NONE, `DM_HALF, 1'b0, 5'd0, `WB_OTHER);
      @(negedge clk);
      drive_nop();
      n_checks++; if (dm_we !== 1'b1 || dm_wstrb !== 4'b1100 || dm_addr !== 32'h200) begin n_fail++; $display("FAIL hstore_ctl: got we=%b strb=%b addr=%h want 1/1100/200", dm_we, dm_wstrb, dm_addr); end
      n_checks++; if (dm_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL hstore_wdata: got %h want abcdabcd", dm_wdata); end
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
      n_checks++; if (write_back_type_output !== `WB_HICCUP || dm_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL hstore_done: got wb=%0d req=%b stall=%b want 0/0/0", write_back_type_output, dm_req, stall); end
      drive(32'hA4, 32'h101, 32'h0000005A, `DM_NONE, `DM_BYTE, 1'b0, 5'd0, `WB_OTHER);
      @(negedge clk);
      drive_nop();
      n_checks++; if (dm_wstrb !== 4'b0010 || dm_wdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL bstore_lane: got strb=%b wdata=%h want 0010/5a5a5a5a", dm_wstrb, dm_wdata); end
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
   endtask

   task automatic test_timeout();
      int  stall_cnt = 0;
      logic seen = 1'b0;
      @(negedge clk);
      drive(32'hB0, 32'h300, 32'h0, `DM_WORD, `DM_NONE, 1'b0, 5'd4, `WB_LOAD);
      @(negedge clk);
      drive_nop();
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus_error) seen = 1'b1;
         else begin
            if (stall) stall_cnt++;
            @(negedge clk);
         end
      end
      n_checks++; if (seen !== 1'b1 || stall_cnt != 16) begin n_fail++; $display("FAIL timeout_pulse: got seen=%b after %0d stall cycles want 1/16", seen, stall_cnt); end
      n_checks++; if (stall !== 1'b0 || dm_req !== 1'b0 || write_back_type_output !== `WB_HICCUP) begin n_fail++; $display("FAIL timeout_release: got stall=%b req=%b wb=%0d want 0/0/0", stall, dm_req, write_back_type_output); end
      @(negedge clk);
      n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", bus_error); end
   endtask

   task automatic test_ack_in_idle();
      @(negedge clk);
      drive_nop();
      dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      dm_ack = 1'b0;
      n_checks++; if (stall !== 1'b0 || dm_req !== 1'b0 || write_back_type_output !== `WB_HICCUP) begin n_fail++; $display("FAIL idle_ack: got stall=%b req=%b wb=%0d want 0/0/0", stall, dm_req, write_back_type_output); end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      drive(32'hC0, 32'h400, 32'h0, `DM_WORD, `DM_NONE, 1'b0, 5'd6, `WB_LOAD);
      @(negedge clk);
      drive_nop();
      n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got req=%b want 1", dm_req); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (dm_req !== 1'b0 || write_back_type_output !== `WB_HICCUP || stall !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got req=%b wb=%0d stall=%b want 0/0/0", dm_req, write_back_type_output, stall); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (dm_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got req=%b stall=%b want 0/0", dm_req, stall); end
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_signed_byte_load();
      test_unsigned_half_load();
      test_misaligned_word_load();
      test_stores();
      test_timeout();
      test_ack_in_idle();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
